// File: rtl/matrix_slot_manager_pkg.sv
// rtl/matrix_slot_manager_pkg.sv - shared constants, error codes and state encoding for the slot manager
package matrix_slot_manager_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_NUM_SLOTS  = 16;
  localparam int DEF_SLOT_SIZE  = 256;
  localparam int DEF_MAX_DIM    = 16;

  localparam int SLOT_W = 4;
  localparam int DIM_W  = 5;
  localparam int CNT_W  = 5;

  localparam logic [3:0] ERR_NONE        = 4'd0;
  localparam logic [3:0] ERR_DIM_RANGE   = 4'd1;
  localparam logic [3:0] ERR_COMMIT_SLOT = 4'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_PENDING = 2'd2
  } mgr_state_t;

  // A dimension is legal when it is non-zero and within both the runtime and hard limits.
  function automatic logic dim_ok(input logic [DIM_W-1:0] dim,
                                 input logic [DIM_W-1:0] limit,
                                 input logic [DIM_W-1:0] hard_max);
    return (dim != '0) && (dim <= limit) && (dim <= hard_max);
  endfunction

endpackage

// File: rtl/matrix_slot_table.sv
// rtl/matrix_slot_table.sv - slot register file with registered query read and first-free encoder
module matrix_slot_table
  import matrix_slot_manager_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SLOTS      = DEF_NUM_SLOTS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [SLOT_W-1:0]     wr_slot,
  input  logic [DIM_W-1:0]      wr_m,
  input  logic [DIM_W-1:0]      wr_n,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  clr_en,
  input  logic [SLOT_W-1:0]     clr_slot,
  input  logic [SLOT_W-1:0]     query_slot,
  output logic                  query_valid,
  output logic [DIM_W-1:0]      query_m,
  output logic [DIM_W-1:0]      query_n,
  output logic [ADDR_WIDTH-1:0] query_addr,
  output logic [CNT_W-1:0]      slot_count,
  output logic [SLOTS-1:0]      live,
  output logic                  free_found,
  output logic [SLOT_W-1:0]     free_slot
);

  logic [SLOTS-1:0]      valid;
  logic [DIM_W-1:0]      m_mem [SLOTS];
  logic [DIM_W-1:0]      n_mem [SLOTS];
  logic [ADDR_WIDTH-1:0] a_mem [SLOTS];

  // Valid vector as it will be after this edge's queued write/clear, so allocation never
  // hands out a slot whose commit is still in flight.
  always_comb begin
    live = valid;
    if (wr_en)  live[wr_slot]  = 1'b1;
    if (clr_en) live[clr_slot] = 1'b0;
  end

  // Lowest-index free slot over the look-ahead valid vector.
  always_comb begin
    free_found = 1'b0;
    free_slot  = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!live[i]) begin
        free_found = 1'b1;
        free_slot  = SLOT_W'(i);
      end
    end
  end

  // Valid bits take the queued write/clear one cycle after the manager issues them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid <= '0;
    else        valid <= live;
  end

  // Matrix descriptors; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      m_mem[wr_slot] <= wr_m;
      n_mem[wr_slot] <= wr_n;
      a_mem[wr_slot] <= wr_addr;
    end
  end

  // Registered lookup and occupancy; invalid slots read back as all zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      query_valid <= 1'b0;
      query_m     <= '0;
      query_n     <= '0;
      query_addr  <= '0;
      slot_count  <= '0;
    end else begin
      query_valid <= valid[query_slot];
      query_m     <= valid[query_slot] ? m_mem[query_slot] : '0;
      query_n     <= valid[query_slot] ? n_mem[query_slot] : '0;
      query_addr  <= valid[query_slot] ? a_mem[query_slot] : '0;
      slot_count  <= CNT_W'($countones(valid));
    end
  end

endmodule

// File: rtl/matrix_slot_manager.sv
// rtl/matrix_slot_manager.sv - alloc/commit/delete control for the matrix slot table
module matrix_slot_manager
  import matrix_slot_manager_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter int SLOT_SIZE  = DEF_SLOT_SIZE,
  parameter int MAX_DIM    = DEF_MAX_DIM
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIM_W-1:0]      config_max_dim,
  input  logic                  alloc_req,
  input  logic                  alloc_abort,
  output logic                  alloc_valid,
  output logic [SLOT_W-1:0]     alloc_slot,
  output logic [ADDR_WIDTH-1:0] alloc_addr,
  input  logic                  commit_req,
  input  logic [SLOT_W-1:0]     commit_slot,
  input  logic [DIM_W-1:0]      commit_m,
  input  logic [DIM_W-1:0]      commit_n,
  input  logic [ADDR_WIDTH-1:0] commit_addr,
  input  logic                  del_req,
  input  logic [SLOT_W-1:0]     del_slot,
  input  logic [SLOT_W-1:0]     query_slot,
  output logic                  query_valid,
  output logic [DIM_W-1:0]      query_m,
  output logic [DIM_W-1:0]      query_n,
  output logic [ADDR_WIDTH-1:0] query_addr,
  output logic [CNT_W-1:0]      slot_count,
  output logic                  pending,
  output logic [3:0]            error_code
);

  mgr_state_t state, state_n;
  logic [SLOT_W-1:0]     res_slot, res_slot_n;
  logic [SLOT_W-1:0]     victim_ptr, victim_n;
  logic [3:0]            err, err_n;
  logic                  wr_en, wr_en_n;
  logic [SLOT_W-1:0]     wr_slot, wr_slot_n;
  logic [DIM_W-1:0]      wr_m, wr_m_n, wr_n, wr_n_n;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_n;
  logic                  clr_en, clr_en_n;
  logic [SLOT_W-1:0]     clr_slot, clr_slot_n;
  logic [NUM_SLOTS-1:0]  live;
  logic                  free_found;
  logic [SLOT_W-1:0]     free_slot;
  logic [ADDR_WIDTH-1:0] res_base;
  logic                  del_hit, commit_match, dims_good;

  assign res_base     = ADDR_WIDTH'(res_slot) * ADDR_WIDTH'(SLOT_SIZE);
  assign commit_match = (commit_slot == res_slot) && (commit_addr == res_base);
  assign dims_good    = dim_ok(commit_m, config_max_dim, DIM_W'(MAX_DIM)) &&
                        dim_ok(commit_n, config_max_dim, DIM_W'(MAX_DIM));
  // The reserved slot is never valid, so deleting it is filtered out explicitly anyway.
  assign del_hit      = del_req && live[del_slot] &&
                        !((state != S_IDLE) && (del_slot == res_slot));

  assign alloc_valid = (state == S_GRANT);
  assign alloc_slot  = res_slot;
  assign alloc_addr  = res_base;
  assign pending     = (state != S_IDLE);
  assign error_code  = err;

  // Next-state logic; abort outranks commit, commit outranks delete, delete defers a new allocation.
  always_comb begin
    state_n    = state;
    res_slot_n = res_slot;
    victim_n   = victim_ptr;
    err_n      = err;
    wr_en_n    = 1'b0;
    wr_slot_n  = res_slot;
    wr_m_n     = commit_m;
    wr_n_n     = commit_n;
    wr_addr_n  = commit_addr;
    clr_en_n   = del_hit;
    clr_slot_n = del_slot;
    unique case (state)
      S_IDLE: begin
        if (!alloc_abort) begin
          if (commit_req) begin
            err_n = ERR_COMMIT_SLOT;
          end else if (!del_req && alloc_req) begin
            state_n = S_GRANT;
            if (free_found) begin
              res_slot_n = free_slot;
            end else begin
              res_slot_n = victim_ptr;
              clr_en_n   = 1'b1;
              clr_slot_n = victim_ptr;
              victim_n   = (victim_ptr == SLOT_W'(NUM_SLOTS - 1)) ? '0 : victim_ptr + 1'b1;
            end
          end
        end
      end
      S_GRANT: begin
        if (alloc_abort) begin
          state_n = S_IDLE;
          err_n   = ERR_NONE;
        end else begin
          state_n = S_PENDING;
          if (commit_req) err_n = ERR_COMMIT_SLOT;
        end
      end
      S_PENDING: begin
        if (alloc_abort) begin
          state_n = S_IDLE;
          err_n   = ERR_NONE;
        end else if (commit_req) begin
          if (!commit_match) begin
            err_n = ERR_COMMIT_SLOT;
          end else if (!dims_good) begin
            err_n   = ERR_DIM_RANGE;
            state_n = S_IDLE;
          end else begin
            wr_en_n = 1'b1;
            err_n   = ERR_NONE;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Control state and the one-cycle table command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      res_slot   <= '0;
      victim_ptr <= '0;
      err        <= ERR_NONE;
      wr_en      <= 1'b0;
      wr_slot    <= '0;
      wr_m       <= '0;
      wr_n       <= '0;
      wr_addr    <= '0;
      clr_en     <= 1'b0;
      clr_slot   <= '0;
    end else begin
      state      <= state_n;
      res_slot   <= res_slot_n;
      victim_ptr <= victim_n;
      err        <= err_n;
      wr_en      <= wr_en_n;
      wr_slot    <= wr_slot_n;
      wr_m       <= wr_m_n;
      wr_n       <= wr_n_n;
      wr_addr    <= wr_addr_n;
      clr_en     <= clr_en_n;
      clr_slot   <= clr_slot_n;
    end
  end

  matrix_slot_table #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLOTS      (NUM_SLOTS)
  ) u_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_slot     (wr_slot),
    .wr_m        (wr_m),
    .wr_n        (wr_n),
    .wr_addr     (wr_addr),
    .clr_en      (clr_en),
    .clr_slot    (clr_slot),
    .query_slot  (query_slot),
    .query_valid (query_valid),
    .query_m     (query_m),
    .query_n     (query_n),
    .query_addr  (query_addr),
    .slot_count  (slot_count),
    .live        (live),
    .free_found  (free_found),
    .free_slot   (free_slot)
  );

endmodule

// File: tb/tb_matrix_slot_manager.sv
// tb/tb_matrix_slot_manager.sv - directed bench with a transaction-level model of the slot manager
module tb_matrix_slot_manager;
  import matrix_slot_manager_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  config_max_dim = 5'd16;
  logic        alloc_req = 1'b0, alloc_abort = 1'b0;
  logic        alloc_valid;
  logic [3:0]  alloc_slot;
  logic [11:0] alloc_addr;
  logic        commit_req = 1'b0;
  logic [3:0]  commit_slot = '0;
  logic [4:0]  commit_m = '0, commit_n = '0;
  logic [11:0] commit_addr = '0;
  logic        del_req = 1'b0;
  logic [3:0]  del_slot = '0;
  logic [3:0]  query_slot = '0;
  logic        query_valid;
  logic [4:0]  query_m, query_n;
  logic [11:0] query_addr;
  logic [4:0]  slot_count;
  logic        pending;
  logic [3:0]  error_code;

  always #5 clk = ~clk;

  matrix_slot_manager dut (
    .clk(clk), .rst_n(rst_n), .config_max_dim(config_max_dim),
    .alloc_req(alloc_req), .alloc_abort(alloc_abort), .alloc_valid(alloc_valid),
    .alloc_slot(alloc_slot), .alloc_addr(alloc_addr),
    .commit_req(commit_req), .commit_slot(commit_slot), .commit_m(commit_m),
    .commit_n(commit_n), .commit_addr(commit_addr),
    .del_req(del_req), .del_slot(del_slot),
    .query_slot(query_slot), .query_valid(query_valid), .query_m(query_m),
    .query_n(query_n), .query_addr(query_addr),
    .slot_count(slot_count), .pending(pending), .error_code(error_code)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_GRANT = 1, M_PEND = 2;
  int ph = M_IDLE, res = 0, victim = 0, merr = 0;
  bit cv[16]; int cm[16], cn[16], ca[16];   // table as of the latest edge
  bit pv[16]; int pm[16], pn[16], pa[16];   // table as of the edge before
  int e_qv = 0, e_qm = 0, e_qn = 0, e_qa = 0, e_cnt = 0;

  task automatic model_reset();
    ph = M_IDLE; res = 0; victim = 0; merr = 0;
    e_qv = 0; e_qm = 0; e_qn = 0; e_qa = 0; e_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cv[i] = 0; cm[i] = 0; cn[i] = 0; ca[i] = 0;
      pv[i] = 0; pm[i] = 0; pn[i] = 0; pa[i] = 0;
    end
  endtask

  function automatic bit dim_legal(input int d);
    return d >= 1 && d <= int'(config_max_dim) && d <= 16;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      int q;
      int pick;
      q = int'(query_slot);
      // query and count reflect the table two edges back
      e_qv = pv[q];
      e_qm = pv[q] ? pm[q] : 0;
      e_qn = pv[q] ? pn[q] : 0;
      e_qa = pv[q] ? pa[q] : 0;
      e_cnt = 0;
      for (int i = 0; i < 16; i++) e_cnt += pv[i];
      pv = cv; pm = cm; pn = cn; pa = ca;
      if (del_req && cv[del_slot] && !(ph != M_IDLE && int'(del_slot) == res))
        cv[del_slot] = 0;
      case (ph)
        M_IDLE: begin
          if (!alloc_abort) begin
            if (commit_req) merr = 2;
            else if (!del_req && alloc_req) begin
              pick = -1;
              for (int i = 0; i < 16; i++) if (!cv[i] && pick < 0) pick = i;
              if (pick < 0) begin
                pick = victim;
                cv[victim] = 0;
                victim = (victim + 1) % 16;
              end
              res = pick;
              ph = M_GRANT;
            end
          end
        end
        M_GRANT: begin
          if (alloc_abort) begin ph = M_IDLE; merr = 0; end
          else begin
            ph = M_PEND;
            if (commit_req) merr = 2;
          end
        end
        default: begin
          if (alloc_abort) begin ph = M_IDLE; merr = 0; end
          else if (commit_req) begin
            if (int'(commit_slot) != res || int'(commit_addr) != res * 256) merr = 2;
            else if (!dim_legal(int'(commit_m)) || !dim_legal(int'(commit_n))) begin
              merr = 1; ph = M_IDLE;
            end else begin
              cv[res] = 1; cm[res] = commit_m; cn[res] = commit_n; ca[res] = commit_addr;
              merr = 0; ph = M_IDLE;
            end
          end
        end
      endcase
    end
  end

  // ---------------- every-cycle compare ----------------
  bit cmp_on = 0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("alloc_valid", alloc_valid, ph == M_GRANT);
      if (ph == M_GRANT) begin
        chk("alloc_slot", alloc_slot, res);
        chk("alloc_addr", alloc_addr, res * 256);
      end
      chk("pending", pending, ph != M_IDLE);
      chk("error_code", error_code, merr);
      chk("query_valid", query_valid, e_qv);
      chk("query_m", query_m, e_qm);
      chk("query_n", query_n, e_qn);
      chk("query_addr", query_addr, e_qa);
      chk("slot_count", slot_count, e_cnt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc_get(output int slot, output int addr);
    bit got;
    got = 0; slot = -1; addr = -1;
    alloc_req = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      step();
      if (alloc_valid) begin got = 1; slot = alloc_slot; addr = alloc_addr; end
    end
    alloc_req = 1'b0;
    if (!got) chk("alloc_timeout", 0, 1);
    step();
  endtask

  task automatic commit(input int s, input int m, input int n, input int a);
    commit_req = 1'b1; commit_slot = 4'(s); commit_m = 5'(m); commit_n = 5'(n); commit_addr = 12'(a);
    step();
    commit_req = 1'b0;
  endtask

  task automatic del(input int s);
    del_req = 1'b1; del_slot = 4'(s);
    step();
    del_req = 1'b0;
  endtask

  initial begin
    int s, a, pulses;
    step();
    chk("rst_alloc_valid", alloc_valid, 0);
    chk("rst_alloc_slot", alloc_slot, 0);
    chk("rst_alloc_addr", alloc_addr, 0);
    chk("rst_pending", pending, 0);
    chk("rst_error", error_code, ERR_NONE);
    chk("rst_query_valid", query_valid, 0);
    chk("rst_count", slot_count, 0);
    cmp_on = 1;
    step();
    rst_n = 1'b1;

    // held request yields a single grant
    pulses = 0;
    alloc_req = 1'b1;
    repeat (4) begin
      step();
      if (alloc_valid) begin
        pulses++;
        chk("t1_slot", alloc_slot, 0);
        chk("t1_addr", alloc_addr, 0);
      end
    end
    alloc_req = 1'b0;
    chk("t1_pulses", pulses, 1);
    chk("t1_pending", pending, 1);

    // first commit becomes visible two edges later
    query_slot = 4'd0;
    commit(0, 3, 4, 0);
    repeat (2) step();
    chk("t2_qv", query_valid, 1);
    chk("t2_qm", query_m, 3);
    chk("t2_qn", query_n, 4);
    chk("t2_qa", query_addr, 0);
    chk("t2_count", slot_count, 1);

    // fill the table, then evict in round-robin order
    for (int i = 1; i < 16; i++) begin
      alloc_get(s, a);
      chk("fill_slot", s, i);
      commit(s, (i % 4) + 1, (i % 3) + 1, s * 256);
    end
    repeat (3) step();
    chk("full_count", slot_count, 16);
    alloc_get(s, a);
    chk("evict0_slot", s, 0);
    chk("evict0_addr", a, 0);
    repeat (2) step();
    chk("evict0_count", slot_count, 15);
    chk("evict0_pending", pending, 1);
    commit(0, 2, 2, 0);
    alloc_get(s, a);
    chk("evict1_slot", s, 1);
    chk("evict1_addr", a, 256);
    commit(1, 16, 16, 256);

    // dimension error releases, slot mismatch holds
    del(2);
    alloc_get(s, a);
    chk("t4_slot", s, 2);
    commit(2, 0, 3, 512);
    chk("t4_dim_err", error_code, ERR_DIM_RANGE);
    chk("t4_dim_pending", pending, 0);
    alloc_get(s, a);
    commit(5, 3, 3, 5 * 256);
    chk("t4_slot_err", error_code, ERR_COMMIT_SLOT);
    chk("t4_slot_pending", pending, 1);
    config_max_dim = 5'd4;
    commit(2, 4, 4, 512);
    chk("t4_limit_ok", error_code, ERR_NONE);
    config_max_dim = 5'd16;

    // abort beats a same-cycle commit
    alloc_get(s, a);
    chk("t5_slot", s, 2);
    commit(7, 1, 1, 7 * 256);
    chk("t5_mismatch", error_code, ERR_COMMIT_SLOT);
    alloc_abort = 1'b1;
    commit(2, 1, 1, 512);
    alloc_abort = 1'b0;
    chk("t5_err", error_code, ERR_NONE);
    chk("t5_pending", pending, 0);
    query_slot = 4'd2;
    repeat (3) step();
    chk("t5_qv", query_valid, 0);

    // delete and commit on different slots in one cycle
    alloc_get(s, a);
    commit(s, 2, 3, s * 256);
    del(7);
    alloc_get(s, a);
    chk("t6_slot", s, 7);
    del_req = 1'b1; del_slot = 4'd3;
    commit(7, 5, 6, 7 * 256);
    del_req = 1'b0;
    repeat (3) step();
    chk("t6_count", slot_count, 15);
    query_slot = 4'd3;
    step();
    chk("t6_q3_valid", query_valid, 0);
    query_slot = 4'd7;
    step();
    chk("t6_q7_valid", query_valid, 1);
    chk("t6_q7_m", query_m, 5);
    chk("t6_q7_n", query_n, 6);
    chk("t6_q7_addr", query_addr, 1792);
    del(3);
    repeat (3) step();
    chk("t6_del_noop_count", slot_count, 15);
    chk("t6_del_noop_err", error_code, ERR_NONE);

    // reset mid-reservation
    alloc_get(s, a);
    chk("t7_slot", s, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_pending", pending, 0);
    chk("t7_count", slot_count, 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("t7_after_count", slot_count, 0);

    cmp_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
